// File: rtl/stb_drain_ctrl_pkg.sv
// Shared types for the store-buffer drain controller.
// Entry layout, FSM encoding and line alignment helper.
package stb_drain_ctrl_pkg;
  localparam int ADDRESS_WIDTH = 32;
  localparam int XLEN = 32;
  localparam int CACHE_LINE_BYTES = 16;
  localparam int LINE_OFF = $clog2(CACHE_LINE_BYTES);

  typedef enum logic {BYTE, WORD} data_size_e;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [XLEN-1:0]          data;
    data_size_e               size;
  } stb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITE,
    FILL_WAIT
  } drain_state_e;

  function automatic logic [ADDRESS_WIDTH-1:0] line_addr(
    input logic [ADDRESS_WIDTH-1:0] a
  );
    return {a[ADDRESS_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  endfunction
endpackage

// File: rtl/stb_drain_ctrl_if.sv
// Flush, D$ and line-fill signals of the drain controller.
// master drives the environment side, slave is the controller.
interface stb_drain_ctrl_if;
  logic flush_in;
  logic [stb_drain_ctrl_pkg::ADDRESS_WIDTH-1:0] flush_addr_in;
  logic [stb_drain_ctrl_pkg::XLEN-1:0] flush_data_in;
  stb_drain_ctrl_pkg::data_size_e flush_size_in;
  logic full_out;
  logic drained_out;
  logic overflow_out;
  logic misaligned_out;
  logic cache_lookup_out;
  logic [stb_drain_ctrl_pkg::ADDRESS_WIDTH-1:0] cache_addr_out;
  logic cache_hit_in;
  logic cache_write_out;
  logic [stb_drain_ctrl_pkg::XLEN-1:0] cache_wdata_out;
  logic [stb_drain_ctrl_pkg::XLEN/8-1:0] cache_byte_en_out;
  logic mem_req_out;
  logic [stb_drain_ctrl_pkg::ADDRESS_WIDTH-1:0] mem_addr_out;
  logic mem_ack_in;

  modport master (
    output flush_in, flush_addr_in, flush_data_in, flush_size_in,
    output cache_hit_in, mem_ack_in,
    input  full_out, drained_out, overflow_out, misaligned_out,
    input  cache_lookup_out, cache_addr_out, cache_write_out,
    input  cache_wdata_out, cache_byte_en_out,
    input  mem_req_out, mem_addr_out
  );

  modport slave (
    input  flush_in, flush_addr_in, flush_data_in, flush_size_in,
    input  cache_hit_in, mem_ack_in,
    output full_out, drained_out, overflow_out, misaligned_out,
    output cache_lookup_out, cache_addr_out, cache_write_out,
    output cache_wdata_out, cache_byte_en_out,
    output mem_req_out, mem_addr_out
  );
endinterface

// File: rtl/stb_drain_ctrl_lane_gen.sv
// Places store data on D$ byte lanes.
// Bytes are replicated so any enabled lane sees the value.
module stb_drain_ctrl_lane_gen
  import stb_drain_ctrl_pkg::*;
(
  input  logic [1:0]        offset,
  input  data_size_e        size,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] byte_en
);
  always_comb begin
    wdata   = data;
    byte_en = '1;
    if (size == BYTE) begin
      wdata   = {(XLEN/8){data[7:0]}};
      byte_en = (XLEN/8)'(1) << offset;
    end
  end
endmodule

// File: rtl/stb_drain_ctrl.sv
// Drains flushed stores into the D$, filling lines on miss.
// Small inline FIFO feeds a lookup/write/fill FSM.
module stb_drain_ctrl
  import stb_drain_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  stb_drain_ctrl_if.slave  bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  stb_entry_t q [QUEUE_DEPTH];
  stb_entry_t entry;
  stb_entry_t head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  drain_state_e state;
  drain_state_e state_nx;
  logic full;
  logic push;
  logic pop;
  logic misaligned;
  logic active;
  logic lookup;
  logic write;
  logic mem_req;
  logic mis_drop;
  logic [XLEN-1:0] wdata;
  logic [XLEN/8-1:0] byte_en;

  assign entry.addr = bus.flush_addr_in;
  assign entry.data = bus.flush_data_in;
  assign entry.size = bus.flush_size_in;

  assign full = (count == CW'(QUEUE_DEPTH));
  assign push = bus.flush_in & ~full;
  assign head = q[rd_ptr];
  assign misaligned = (head.size == WORD) && (head.addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    lookup   = 1'b0;
    write    = 1'b0;
    mem_req  = 1'b0;
    mis_drop = 1'b0;
    unique case (state)
      IDLE: begin
        // Entering on the push itself keeps flush-to-lookup at one cycle.
        if (count != '0 || push) state_nx = LOOKUP;
      end
      LOOKUP: begin
        lookup = 1'b1;
        if (misaligned) begin
          pop      = 1'b1;
          mis_drop = 1'b1;
          state_nx = IDLE;
        end else if (bus.cache_hit_in) begin
          state_nx = WRITE;
        end else begin
          state_nx = FILL_WAIT;
        end
      end
      WRITE: begin
        write    = 1'b1;
        pop      = 1'b1;
        state_nx = (count > CW'(1) || push) ? LOOKUP : IDLE;
      end
      FILL_WAIT: begin
        mem_req = 1'b1;
        if (bus.mem_ack_in) state_nx = LOOKUP;
      end
      default: state_nx = IDLE;
    endcase
  end

  stb_drain_ctrl_lane_gen u_lane_gen (
    .offset  (head.addr[1:0]),
    .size    (head.size),
    .data    (head.data),
    .wdata   (wdata),
    .byte_en (byte_en)
  );

  assign active = (state == LOOKUP) || (state == WRITE);

  assign bus.full_out          = full;
  assign bus.drained_out       = (count == '0) && (state == IDLE);
  assign bus.overflow_out      = bus.flush_in & full;
  assign bus.misaligned_out    = mis_drop;
  assign bus.cache_lookup_out  = lookup;
  assign bus.cache_addr_out    = active ? {head.addr[ADDRESS_WIDTH-1:2], 2'b00} : '0;
  assign bus.cache_write_out   = write;
  assign bus.cache_wdata_out   = active ? wdata : '0;
  assign bus.cache_byte_en_out = active ? byte_en : '0;
  assign bus.mem_req_out       = mem_req;
  assign bus.mem_addr_out      = mem_req ? line_addr(head.addr) : '0;
endmodule

// File: tb/tb_stb_drain_ctrl.sv
// Directed bench for the store-buffer drain controller.
// Each task drives one scenario and checks cycle by cycle.
module tb_stb_drain_ctrl;
  import stb_drain_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  stb_drain_ctrl_if b ();

  stb_drain_ctrl #(.QUEUE_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input logic [31:0] a, input logic [31:0] d,
                       input data_size_e s);
    b.flush_in = 1'b1;
    b.flush_addr_in = a;
    b.flush_data_in = d;
    b.flush_size_in = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b.flush_in = 1'b0;
    b.flush_addr_in = '0;
    b.flush_data_in = '0;
    b.flush_size_in = WORD;
    b.cache_hit_in = 1'b0;
    b.mem_ack_in = 1'b0;
    repeat (3) next();
    reset = 1'b0;
    #1;
    vectors++;
    if ({b.full_out, b.drained_out, b.overflow_out, b.misaligned_out,
         b.cache_lookup_out, b.cache_write_out, b.mem_req_out} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 0100000",
        {b.full_out, b.drained_out, b.overflow_out, b.misaligned_out,
         b.cache_lookup_out, b.cache_write_out, b.mem_req_out});
    end
    vectors++;
    if ({b.cache_addr_out, b.cache_wdata_out, b.cache_byte_en_out, b.mem_addr_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_buses got %h %h %h %h exp 0", b.cache_addr_out,
        b.cache_wdata_out, b.cache_byte_en_out, b.mem_addr_out);
    end
    b.mem_ack_in = 1'b1;
    next();
    b.mem_ack_in = 1'b0;
    #1;
    vectors++;
    if ({b.drained_out, b.cache_lookup_out, b.mem_req_out} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_stray_ack got %b exp 100",
        {b.drained_out, b.cache_lookup_out, b.mem_req_out});
    end
  endtask

  task automatic test_word_hit();
    flush(32'h100, 32'hDEADBEEF, WORD);
    next();
    b.flush_in = 1'b0;
    b.cache_hit_in = 1'b1;
    #1;
    vectors++;
    if ({b.cache_lookup_out, b.cache_write_out, b.cache_addr_out} !== {2'b10, 32'h100}) begin
      miscompares++;
      $display("FAIL word_lookup got %b%b %h exp 10 00000100",
        b.cache_lookup_out, b.cache_write_out, b.cache_addr_out);
    end
    next();
    vectors++;
    if ({b.cache_write_out, b.cache_byte_en_out, b.cache_wdata_out} !== {1'b1, 4'hF, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL word_write got %b %h %h exp 1 f deadbeef",
        b.cache_write_out, b.cache_byte_en_out, b.cache_wdata_out);
    end
    next();
    b.cache_hit_in = 1'b0;
    #1;
    vectors++;
    if ({b.drained_out, b.cache_write_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL word_drained got %b exp 10", {b.drained_out, b.cache_write_out});
    end
  endtask

  task automatic test_byte_hit();
    flush(32'h203, 32'h000000AB, BYTE);
    next();
    b.flush_in = 1'b0;
    b.cache_hit_in = 1'b1;
    #1;
    vectors++;
    if (b.cache_addr_out !== 32'h200) begin
      miscompares++;
      $display("FAIL byte_addr got %h exp 00000200", b.cache_addr_out);
    end
    next();
    vectors++;
    if ({b.cache_write_out, b.cache_byte_en_out, b.cache_wdata_out} !== {1'b1, 4'b1000, 32'hABABABAB}) begin
      miscompares++;
      $display("FAIL byte_write got %b %b %h exp 1 1000 abababab",
        b.cache_write_out, b.cache_byte_en_out, b.cache_wdata_out);
    end
    next();
    b.cache_hit_in = 1'b0;
    #1;
  endtask

  task automatic test_miss_fill();
    flush(32'h344, 32'h11223344, WORD);
    next();
    b.flush_in = 1'b0;
    #1;
    vectors++;
    if ({b.cache_lookup_out, b.mem_req_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL miss_lookup got %b exp 10", {b.cache_lookup_out, b.mem_req_out});
    end
    next();
    flush(32'h400, 32'h55667788, WORD);
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if ({b.mem_req_out, b.mem_addr_out, b.cache_write_out} !== {1'b1, 32'h340, 1'b0}) begin
        miscompares++;
        $display("FAIL miss_fill_wait[%0d] got %b %h %b exp 1 00000340 0", i,
          b.mem_req_out, b.mem_addr_out, b.cache_write_out);
      end
      next();
      b.flush_in = 1'b0;
    end
    b.mem_ack_in = 1'b1;
    #1;
    vectors++;
    if ({b.mem_req_out, b.full_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL miss_ack_cycle got %b exp 11", {b.mem_req_out, b.full_out});
    end
    next();
    b.mem_ack_in = 1'b0;
    b.cache_hit_in = 1'b1;
    #1;
    vectors++;
    if ({b.mem_req_out, b.cache_lookup_out, b.cache_addr_out} !== {2'b01, 32'h344}) begin
      miscompares++;
      $display("FAIL miss_retry got %b%b %h exp 01 00000344",
        b.mem_req_out, b.cache_lookup_out, b.cache_addr_out);
    end
    next();
    vectors++;
    if ({b.cache_write_out, b.cache_wdata_out} !== {1'b1, 32'h11223344}) begin
      miscompares++;
      $display("FAIL miss_write1 got %b %h exp 1 11223344", b.cache_write_out, b.cache_wdata_out);
    end
    next();
    vectors++;
    if ({b.cache_lookup_out, b.cache_addr_out} !== {1'b1, 32'h400}) begin
      miscompares++;
      $display("FAIL miss_lookup2 got %b %h exp 1 00000400", b.cache_lookup_out, b.cache_addr_out);
    end
    next();
    vectors++;
    if ({b.cache_write_out, b.cache_wdata_out} !== {1'b1, 32'h55667788}) begin
      miscompares++;
      $display("FAIL miss_write2 got %b %h exp 1 55667788", b.cache_write_out, b.cache_wdata_out);
    end
    next();
    b.cache_hit_in = 1'b0;
    #1;
    vectors++;
    if (b.drained_out !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_drained got %b exp 1", b.drained_out);
    end
  endtask

  task automatic test_overflow();
    flush(32'h500, 32'h1, WORD);
    next();
    flush(32'h504, 32'h2, WORD);
    #1;
    vectors++;
    if ({b.full_out, b.overflow_out} !== 2'b00) begin
      miscompares++;
      $display("FAIL ovf_one got %b exp 00", {b.full_out, b.overflow_out});
    end
    next();
    flush(32'h508, 32'h3, WORD);
    #1;
    vectors++;
    if ({b.full_out, b.overflow_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL ovf_third got %b exp 11", {b.full_out, b.overflow_out});
    end
    next();
    b.flush_in = 1'b0;
    b.mem_ack_in = 1'b1;
    #1;
    vectors++;
    if ({b.full_out, b.overflow_out, b.mem_req_out, b.mem_addr_out} !== {3'b101, 32'h500}) begin
      miscompares++;
      $display("FAIL ovf_hold got %b%b%b %h exp 101 00000500",
        b.full_out, b.overflow_out, b.mem_req_out, b.mem_addr_out);
    end
    next();
    b.mem_ack_in = 1'b0;
    b.cache_hit_in = 1'b1;
    next();
    vectors++;
    if ({b.cache_write_out, b.cache_wdata_out} !== {1'b1, 32'h1}) begin
      miscompares++;
      $display("FAIL ovf_write1 got %b %h exp 1 00000001", b.cache_write_out, b.cache_wdata_out);
    end
    next();
    next();
    vectors++;
    if ({b.cache_write_out, b.cache_wdata_out, b.full_out} !== {1'b1, 32'h2, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_write2 got %b %h %b exp 1 00000002 0",
        b.cache_write_out, b.cache_wdata_out, b.full_out);
    end
    next();
    b.cache_hit_in = 1'b0;
    #1;
    vectors++;
    if ({b.drained_out, b.cache_lookup_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL ovf_dropped got %b exp 10", {b.drained_out, b.cache_lookup_out});
    end
  endtask

  task automatic test_misaligned();
    flush(32'h102, 32'hCAFEF00D, WORD);
    next();
    b.flush_in = 1'b0;
    b.cache_hit_in = 1'b1;
    #1;
    vectors++;
    if ({b.misaligned_out, b.cache_lookup_out, b.cache_write_out} !== 3'b110) begin
      miscompares++;
      $display("FAIL mis_pulse got %b exp 110",
        {b.misaligned_out, b.cache_lookup_out, b.cache_write_out});
    end
    next();
    b.cache_hit_in = 1'b0;
    #1;
    vectors++;
    if ({b.misaligned_out, b.cache_write_out, b.drained_out} !== 3'b001) begin
      miscompares++;
      $display("FAIL mis_popped got %b exp 001",
        {b.misaligned_out, b.cache_write_out, b.drained_out});
    end
  endtask

  task automatic test_reset_mid_fill();
    flush(32'h600, 32'h77, WORD);
    next();
    b.flush_in = 1'b0;
    next();
    vectors++;
    if (b.mem_req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_fill_req got %b exp 1", b.mem_req_out);
    end
    reset = 1'b1;
    next();
    reset = 1'b0;
    b.mem_ack_in = 1'b1;
    #1;
    vectors++;
    if ({b.mem_req_out, b.drained_out} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_fill_drop got %b exp 01", {b.mem_req_out, b.drained_out});
    end
    next();
    b.mem_ack_in = 1'b0;
    b.cache_hit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({b.cache_write_out, b.cache_lookup_out, b.drained_out} !== 3'b001) begin
        miscompares++;
        $display("FAIL rst_no_write[%0d] got %b exp 001", i,
          {b.cache_write_out, b.cache_lookup_out, b.drained_out});
      end
      next();
    end
    b.cache_hit_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_hit();
    test_byte_hit();
    test_miss_fill();
    test_overflow();
    test_misaligned();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
